// File: rtl/wb_retire_buf_pkg.sv
// Shared sizing for the writeback retire buffer and the dispatch-side track FIFO.
// Both must agree on depth and tag width, so they are defined in one place.
package wb_retire_buf_pkg;
  localparam int WITF_DEPTH  = 4;
  localparam int WITF_AWIDTH = $clog2(WITF_DEPTH);
  localparam int REG_AWIDTH  = 5;
  localparam int DATA_XLEN   = 64;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } cmp_src_e;
endpackage

// File: rtl/wb_retire_buf_wrb_entry.sv
// One retire-buffer slot: vld/done control bits plus rd/data payload.
// Payload flops carry no reset; readers gate on vld & done.
module wrb_entry #(
  parameter int RAW  = 5,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            set_i,
  input  logic [RAW-1:0]  set_rd_i,
  input  logic            cmp_i,
  input  logic [XLEN-1:0] cmp_data_i,
  input  logic            clr_i,
  output logic            vld_o,
  output logic            done_o,
  output logic [RAW-1:0]  rd_o,
  output logic [XLEN-1:0] data_o
);
  logic            vld_q, vld_d;
  logic            done_q, done_d;
  logic [RAW-1:0]  rd_q;
  logic [XLEN-1:0] data_q;

  always_comb begin
    vld_d  = vld_q;
    done_d = done_q;
    if (flush_i) begin
      vld_d  = 1'b0;
      done_d = 1'b0;
    end else begin
      if (set_i) begin
        vld_d  = 1'b1;
        done_d = 1'b0;
      end
      if (cmp_i) done_d = 1'b1;
      if (clr_i) begin
        vld_d  = 1'b0;
        done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (set_i) rd_q <= set_rd_i;
    if (cmp_i) data_q <= cmp_data_i;
  end

  assign vld_o  = vld_q;
  assign done_o = done_q;
  assign rd_o   = rd_q;
  assign data_o = data_q;
endmodule

// File: rtl/wb_retire_buf.sv
// In-order writeback retire buffer: out-of-order ALU/LSU completions are
// retired to the register file in allocation order, one isWB pulse per entry.
module wb_retire_buf
  import wb_retire_buf_pkg::*;
#(
  parameter int DEPTH  = WITF_DEPTH,
  parameter int AWIDTH = WITF_AWIDTH,
  parameter int XLEN   = DATA_XLEN,
  parameter int RAW    = REG_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_vld,
  input  logic [RAW-1:0]    alloc_rd,
  output logic [AWIDTH-1:0] alloc_tag,
  output logic              full,
  output logic              empty,
  input  logic              alu_vld,
  input  logic [AWIDTH-1:0] alu_tag,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_vld,
  input  logic [AWIDTH-1:0] lsu_tag,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_wen,
  output logic [RAW-1:0]    rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              isWB,
  output logic              cmp_err
);
  // Pointers carry a wrap flag in the MSB to tell full from empty.
  logic [AWIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  vld, done, set_en, cmp_en, clr_en;
  logic [RAW-1:0]    rd_arr   [DEPTH];
  logic [XLEN-1:0]   data_arr [DEPTH];
  logic [XLEN-1:0]   cmp_data [DEPTH];
  logic [AWIDTH-1:0] head, widx;
  logic              retire, do_alloc, do_retire;
  logic              alu_ok, lsu_ok, same_tag, alu_take, err_evt;

  assign head  = rptr_q[AWIDTH-1:0];
  assign widx  = wptr_q[AWIDTH-1:0];
  assign empty = (wptr_q == rptr_q);
  assign full  = (widx == head) && (wptr_q[AWIDTH] != rptr_q[AWIDTH]);

  assign retire    = vld[head] & done[head];
  assign do_alloc  = alloc_vld & ~full & ~flush;
  assign do_retire = retire & ~flush;

  assign alu_ok   = alu_vld & vld[alu_tag] & ~done[alu_tag];
  assign lsu_ok   = lsu_vld & vld[lsu_tag] & ~done[lsu_tag];
  assign same_tag = alu_vld & lsu_vld & (alu_tag == lsu_tag);
  assign alu_take = alu_ok & ~same_tag;
  assign err_evt  = (alloc_vld & full) | (alu_vld & ~alu_ok) |
                    (lsu_vld & ~lsu_ok) | same_tag;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    cmp_src_e src;
    assign src = (lsu_ok && lsu_tag == AWIDTH'(i))   ? SRC_LSU :
                 (alu_take && alu_tag == AWIDTH'(i)) ? SRC_ALU : SRC_NONE;
    assign set_en[i]   = do_alloc && (widx == AWIDTH'(i));
    assign cmp_en[i]   = ~flush && (src != SRC_NONE);
    assign cmp_data[i] = (src == SRC_LSU) ? lsu_data : alu_data;
    assign clr_en[i]   = do_retire && (head == AWIDTH'(i));

    wrb_entry #(.RAW(RAW), .XLEN(XLEN)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (flush),
      .set_i     (set_en[i]),
      .set_rd_i  (alloc_rd),
      .cmp_i     (cmp_en[i]),
      .cmp_data_i(cmp_data[i]),
      .clr_i     (clr_en[i]),
      .vld_o     (vld[i]),
      .done_o    (done[i]),
      .rd_o      (rd_arr[i]),
      .data_o    (data_arr[i])
    );
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    err_d  = err_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_alloc)  wptr_d = wptr_q + 1'b1;
      if (do_retire) rptr_d = rptr_q + 1'b1;
      if (err_evt)   err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  assign alloc_tag = widx;
  assign isWB      = retire;
  assign rf_wen    = retire & (|rd_arr[head]);
  assign rf_waddr  = retire ? rd_arr[head] : '0;
  assign rf_wdata  = retire ? data_arr[head] : '0;
  assign cmp_err   = err_q;
endmodule

// File: tb/tb_wb_retire_buf.sv
// Directed table-driven bench for wb_retire_buf: each row drives one cycle of
// inputs and states the outputs expected during that cycle.
module tb_wb_retire_buf;
  logic        clk = 1'b0;
  logic        rst, flush, alloc_vld, alu_vld, lsu_vld;
  logic [4:0]  alloc_rd;
  logic [1:0]  alloc_tag, alu_tag, lsu_tag;
  logic [63:0] alu_data, lsu_data;
  logic        full, empty, rf_wen, isWB, cmp_err;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_buf dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_vld(alloc_vld), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .full(full), .empty(empty),
    .alu_vld(alu_vld), .alu_tag(alu_tag), .alu_data(alu_data),
    .lsu_vld(lsu_vld), .lsu_tag(lsu_tag), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .isWB(isWB), .cmp_err(cmp_err)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic        full, empty, wb, wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        err;
  } obs_t;

  typedef struct {
    logic        r, f, av;
    logic [4:0]  ard;
    logic        aluv;
    logic [1:0]  alut;
    logic [63:0] alud;
    logic        lsuv;
    logic [1:0]  lsut;
    logic [63:0] lsud;
    obs_t        exp;
  } vec_t;

  vec_t vecs[$];
  obs_t act;
  assign act = {alloc_tag, full, empty, isWB, rf_wen, rf_waddr, rf_wdata, cmp_err};

  task automatic add(input logic r, f, av, input logic [4:0] ard,
                     input logic aluv, input logic [1:0] alut, input logic [63:0] alud,
                     input logic lsuv, input logic [1:0] lsut, input logic [63:0] lsud,
                     input logic [1:0] etag, input logic efull, eempty, ewb, ewen,
                     input logic [4:0] ewaddr, input logic [63:0] ewdata, input logic eerr);
    vec_t v;
    v.r = r; v.f = f; v.av = av; v.ard = ard;
    v.aluv = aluv; v.alut = alut; v.alud = alud;
    v.lsuv = lsuv; v.lsut = lsut; v.lsud = lsud;
    v.exp = {etag, efull, eempty, ewb, ewen, ewaddr, ewdata, eerr};
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_vld = 0; alloc_rd = 0;
    alu_vld = 0; alu_tag = 0; alu_data = 0;
    lsu_vld = 0; lsu_tag = 0; lsu_data = 0;
  endtask

  task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial begin
    // Reset held two cycles under random stimulus
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      flush = 1'($urandom); alloc_vld = 1'($urandom); alloc_rd = 5'($urandom);
      alu_vld = 1'($urandom); alu_tag = 2'($urandom); alu_data = {$urandom, $urandom};
      lsu_vld = 1'($urandom); lsu_tag = 2'($urandom); lsu_data = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    check1("rst_empty", 64'(empty), 64'd1);
    check1("rst_full", 64'(full), 64'd0);
    check1("rst_tag", 64'(alloc_tag), 64'd0);
    check1("rst_isWB", 64'(isWB), 64'd0);
    check1("rst_wen", 64'(rf_wen), 64'd0);
    check1("rst_waddr", 64'(rf_waddr), 64'd0);
    check1("rst_wdata", rf_wdata, 64'd0);
    check1("rst_err", 64'(cmp_err), 64'd0);

    // r f av ard | aluv alut alud | lsuv lsut lsud || tag full empty wb wen waddr wdata err
    add(1,0,1,5, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,0);
    add(1,0,1,6, 0,0,0,       0,0,0,       1,0,0,0,0,0,0,0);
    add(1,0,1,7, 0,0,0,       0,0,0,       2,0,0,0,0,0,0,0);
    add(1,0,0,0, 1,2,'h33,    0,0,0,       3,0,0,0,0,0,0,0);
    add(1,0,0,0, 1,1,'h22,    0,0,0,       3,0,0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,       1,0,'h11,    3,0,0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       3,0,0,1,1,5,'h11,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       3,0,0,1,1,6,'h22,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       3,0,0,1,1,7,'h33,0);
    add(0,0,0,0, 0,0,0,       0,0,0,       3,0,1,0,0,0,0,0);
    // full, overflow, wrap
    add(1,0,1,1, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,0);
    add(1,0,1,2, 0,0,0,       0,0,0,       1,0,0,0,0,0,0,0);
    add(1,0,1,3, 0,0,0,       0,0,0,       2,0,0,0,0,0,0,0);
    add(1,0,1,4, 0,0,0,       0,0,0,       3,0,0,0,0,0,0,0);
    add(1,0,1,9, 0,0,0,       0,0,0,       0,1,0,0,0,0,0,0);
    add(1,0,0,0, 1,0,'h01,    1,1,'h02,    0,1,0,0,0,0,0,1);
    add(1,0,1,10,1,2,'h03,    1,3,'h04,    0,1,0,1,1,1,'h01,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,0,1,1,2,'h02,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,0,1,1,3,'h03,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,0,1,1,4,'h04,1);
    add(1,0,1,12,0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    add(1,0,0,0, 1,0,'h55,    0,0,0,       1,0,0,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       1,0,0,1,1,12,'h55,1);
    add(0,0,0,0, 0,0,0,       0,0,0,       1,0,1,0,0,0,0,1);
    // dual completion, then same-tag collision
    add(1,0,1,3, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,0);
    add(1,0,1,4, 0,0,0,       0,0,0,       1,0,0,0,0,0,0,0);
    add(1,0,0,0, 1,0,'hA,     1,1,'hB,     2,0,0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       2,0,0,1,1,3,'hA,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       2,0,0,1,1,4,'hB,0);
    add(1,0,1,8, 0,0,0,       0,0,0,       2,0,1,0,0,0,0,0);
    add(1,0,0,0, 1,2,'hAA,    1,2,'hBB,    3,0,0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       3,0,0,1,1,8,'hBB,1);
    // x0 destination
    add(1,0,1,0, 0,0,0,       0,0,0,       3,0,1,0,0,0,0,1);
    add(1,0,0,0, 1,3,'h77,    0,0,0,       0,0,0,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,0,1,0,0,'h77,1);
    add(0,0,0,0, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    // completion to an invalid slot
    add(1,0,0,0, 1,1,'h5,     0,0,0,       0,0,1,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    // flush with a done head and a completion in flight
    add(1,0,1,1, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    add(1,0,1,2, 0,0,0,       0,0,0,       1,0,0,0,0,0,0,1);
    add(1,0,1,3, 0,0,0,       1,0,'h9,     2,0,0,0,0,0,0,1);
    add(1,1,1,4, 1,1,'h8,     0,0,0,       3,0,0,1,1,1,'h9,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    add(1,0,1,6, 0,0,0,       0,0,0,       0,0,1,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,       0,0,0,       1,0,0,0,0,0,0,1);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].r; flush = vecs[k].f; alloc_vld = vecs[k].av; alloc_rd = vecs[k].ard;
      alu_vld = vecs[k].aluv; alu_tag = vecs[k].alut; alu_data = vecs[k].alud;
      lsu_vld = vecs[k].lsuv; lsu_tag = vecs[k].lsut; lsu_data = vecs[k].lsud;
      #1;
      checks++;
      if (act !== vecs[k].exp) begin
        errors++;
        $display("FAIL vec%0d: got tag=%0d full=%0b empty=%0b wb=%0b wen=%0b waddr=%0d wdata=%0h err=%0b expected tag=%0d full=%0b empty=%0b wb=%0b wen=%0b waddr=%0d wdata=%0h err=%0b",
                 k, act.tag, act.full, act.empty, act.wb, act.wen, act.waddr, act.wdata, act.err,
                 vecs[k].exp.tag, vecs[k].exp.full, vecs[k].exp.empty, vecs[k].exp.wb,
                 vecs[k].exp.wen, vecs[k].exp.waddr, vecs[k].exp.wdata, vecs[k].exp.err);
      end
    end

    // Mid-operation reset while a retire is being presented
    @(negedge clk);
    rst = 1; idle_inputs();
    alu_vld = 1; alu_tag = 0; alu_data = 64'h66;
    @(negedge clk);
    idle_inputs();
    #1;
    check1("midrst_pre_wb", 64'(isWB), 64'd1);
    check1("midrst_pre_data", rf_wdata, 64'h66);
    rst = 0;
    @(posedge clk); #1;
    check1("midrst_isWB", 64'(isWB), 64'd0);
    check1("midrst_empty", 64'(empty), 64'd1);
    check1("midrst_tag", 64'(alloc_tag), 64'd0);
    check1("midrst_err", 64'(cmp_err), 64'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
